// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter
// N-master AHB-Lite arbiter and multiplexer in front of the system bus decoder.
// Each master has a one-entry address-phase buffer. A master that loses
// arbitration has its address captured and is stalled in its data phase, so it
// never sees a dropped address.
//
// Parameters
//   NM        number of masters (2..4); master 0 is the CPU
//   ARB_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
// Ports
//   HCLK, HRESET                     clock, synchronous active-high reset
//   M_HADDR/HTRANS/HWRITE/HSIZE/HWDATA  packed per-master request inputs
//   M_HREADY                         per-master ready
//   M_HRDATA                         read data broadcast (equals S_HRDATA)
//   S_HADDR/HTRANS/HWRITE/HSIZE/HWDATA  muxed request to the slave side
//   S_HREADY, S_HRDATA               slave response
//   S_HMASTER                        master owning the current address phase
module ahbl_master_arbiter #(
  parameter int NM       = 2,
  parameter int ARB_MODE = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NM*32-1:0] M_HADDR,
  input  logic [NM*2-1:0]  M_HTRANS,
  input  logic [NM-1:0]    M_HWRITE,
  input  logic [NM*3-1:0]  M_HSIZE,
  input  logic [NM*32-1:0] M_HWDATA,
  output logic [NM-1:0]    M_HREADY,
  output logic [31:0]      M_HRDATA,
  output logic [31:0]      S_HADDR,
  output logic [1:0]       S_HTRANS,
  output logic             S_HWRITE,
  output logic [2:0]       S_HSIZE,
  output logic [31:0]      S_HWDATA,
  input  logic             S_HREADY,
  input  logic [31:0]      S_HRDATA,
  output logic [1:0]       S_HMASTER
);

  localparam int IW = (NM > 2) ? 2 : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  // Per-master address-phase buffers
  logic          pend_reg   [NM];
  logic [31:0]   baddr_reg  [NM];
  logic          bwrite_reg [NM];
  logic [2:0]    bsize_reg  [NM];

  // Global state
  logic          dvalid_reg;
  logic [IW-1:0] downer_reg;
  logic          lock_reg;
  logic [IW-1:0] lidx_reg;
  logic [IW-1:0] last_reg;

  // Unpacked views of the master inputs
  logic [31:0]   m_addr  [NM];
  logic          m_write [NM];
  logic [2:0]    m_size  [NM];
  logic [31:0]   m_wdata [NM];

  logic          ready [NM];
  logic          live  [NM];
  logic          req   [NM];
  logic          take  [NM];
  logic [NM-1:0] unused_trans_lsb;

  // Priority chains: pre_* is "some lower index already requested",
  // enc_* accumulates the index of the first requester.
  logic          pre_all [NM+1];
  logic          pre_hi  [NM+1];
  logic [IW-1:0] enc_all [NM+1];
  logic [IW-1:0] enc_hi  [NM+1];

  logic          sel_valid;
  logic [IW-1:0] sel;
  logic          accept;
  logic          out_en;
  logic [31:0]   sel_addr;
  logic          sel_write;
  logic [2:0]    sel_size;

  assign pre_all[0] = 1'b0;
  assign pre_hi[0]  = 1'b0;
  assign enc_all[0] = '0;
  assign enc_hi[0]  = '0;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : gen_master
      logic hi_req;

      assign m_addr[gi]  = M_HADDR[32*gi +: 32];
      assign m_write[gi] = M_HWRITE[gi];
      assign m_size[gi]  = M_HSIZE[3*gi +: 3];
      assign m_wdata[gi] = M_HWDATA[32*gi +: 32];
      // SEQ is treated as NONSEQ and BUSY as IDLE, so only bit 1 matters.
      assign unused_trans_lsb[gi] = M_HTRANS[2*gi];

      assign ready[gi]    = (dvalid_reg && (downer_reg == IW'(gi))) ? S_HREADY : !pend_reg[gi];
      assign M_HREADY[gi] = HRESET | ready[gi];
      assign live[gi]     = ready[gi] & M_HTRANS[2*gi+1];
      assign req[gi]      = pend_reg[gi] | live[gi];
      assign take[gi]     = accept && (sel == IW'(gi));

      // Round-robin candidates are those strictly above the last issued index;
      // if none, the plain lowest-index winner wraps around.
      assign hi_req       = req[gi] && (IW'(gi) > last_reg);
      assign pre_all[gi+1] = pre_all[gi] | req[gi];
      assign pre_hi[gi+1]  = pre_hi[gi] | hi_req;
      assign enc_all[gi+1] = enc_all[gi] | ((req[gi] && !pre_all[gi]) ? IW'(gi) : '0);
      assign enc_hi[gi+1]  = enc_hi[gi] | ((hi_req && !pre_hi[gi]) ? IW'(gi) : '0);

      // A live request that is not issued this cycle is parked in the buffer,
      // including the winner during a stall; that keeps the slave-side
      // address stable from the buffer while the selection is locked.
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          pend_reg[gi] <= 1'b0;
        end else if (live[gi] && !take[gi]) begin
          pend_reg[gi]   <= 1'b1;
          baddr_reg[gi]  <= m_addr[gi];
          bwrite_reg[gi] <= m_write[gi];
          bsize_reg[gi]  <= m_size[gi];
        end else if (take[gi]) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    sel_valid = lock_reg | pre_all[NM];
    if (lock_reg) begin
      sel = lidx_reg;
    end else if ((ARB_MODE == 1) && pre_hi[NM]) begin
      sel = enc_hi[NM];
    end else begin
      sel = enc_all[NM];
    end
    if (pend_reg[sel]) begin
      sel_addr  = baddr_reg[sel];
      sel_write = bwrite_reg[sel];
      sel_size  = bsize_reg[sel];
    end else begin
      sel_addr  = m_addr[sel];
      sel_write = m_write[sel];
      sel_size  = m_size[sel];
    end
  end

  assign accept = sel_valid & S_HREADY;
  assign out_en = sel_valid & ~HRESET;

  assign S_HTRANS  = out_en ? TR_NONSEQ : TR_IDLE;
  assign S_HADDR   = out_en ? sel_addr : '0;
  assign S_HWRITE  = out_en & sel_write;
  assign S_HSIZE   = out_en ? sel_size : '0;
  assign S_HMASTER = out_en ? 2'(sel) : 2'b00;
  assign S_HWDATA  = m_wdata[downer_reg];
  assign M_HRDATA  = S_HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dvalid_reg <= 1'b0;
      downer_reg <= '0;
      lock_reg   <= 1'b0;
      lidx_reg   <= '0;
      last_reg   <= IW'(NM-1);
    end else if (accept) begin
      dvalid_reg <= 1'b1;
      downer_reg <= sel;
      lock_reg   <= 1'b0;
      if (ARB_MODE == 1) begin
        last_reg <= sel;
      end
    end else if (S_HREADY) begin
      dvalid_reg <= 1'b0;
    end else if (sel_valid) begin
      // Slave stalled with an address presented: freeze the selection.
      lock_reg <= 1'b1;
      lidx_reg <= sel;
    end
  end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Testbench for ahbl_master_arbiter: a fixed-priority 2-master instance and a
// round-robin 3-master instance. Expected slave-side issues are queued when
// stimulus is driven and popped by per-instance monitors on each accepted
// address phase.
module tb_ahbl_master_arbiter;

  typedef struct packed {
    logic [1:0]  m;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        s_hready;
  logic [31:0] s_hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Fixed-priority instance, NM=2
  logic [63:0] fp_haddr, fp_hwdata;
  logic [3:0]  fp_htrans;
  logic [1:0]  fp_hwrite;
  logic [5:0]  fp_hsize;
  logic [1:0]  fp_m_hready;
  logic [31:0] fp_m_hrdata, fp_s_haddr, fp_s_hwdata;
  logic [1:0]  fp_s_htrans, fp_s_hmaster;
  logic        fp_s_hwrite;
  logic [2:0]  fp_s_hsize;

  // Round-robin instance, NM=3
  logic [95:0] rr_haddr, rr_hwdata;
  logic [5:0]  rr_htrans;
  logic [2:0]  rr_hwrite;
  logic [8:0]  rr_hsize;
  logic [2:0]  rr_m_hready;
  logic [31:0] rr_m_hrdata, rr_s_haddr, rr_s_hwdata;
  logic [1:0]  rr_s_htrans, rr_s_hmaster;
  logic        rr_s_hwrite;
  logic [2:0]  rr_s_hsize;

  ahbl_master_arbiter #(.NM(2), .ARB_MODE(0)) u_fp (
    .HCLK(clk), .HRESET(srst),
    .M_HADDR(fp_haddr), .M_HTRANS(fp_htrans), .M_HWRITE(fp_hwrite),
    .M_HSIZE(fp_hsize), .M_HWDATA(fp_hwdata), .M_HREADY(fp_m_hready),
    .M_HRDATA(fp_m_hrdata), .S_HADDR(fp_s_haddr), .S_HTRANS(fp_s_htrans),
    .S_HWRITE(fp_s_hwrite), .S_HSIZE(fp_s_hsize), .S_HWDATA(fp_s_hwdata),
    .S_HREADY(s_hready), .S_HRDATA(s_hrdata), .S_HMASTER(fp_s_hmaster)
  );

  ahbl_master_arbiter #(.NM(3), .ARB_MODE(1)) u_rr (
    .HCLK(clk), .HRESET(srst),
    .M_HADDR(rr_haddr), .M_HTRANS(rr_htrans), .M_HWRITE(rr_hwrite),
    .M_HSIZE(rr_hsize), .M_HWDATA(rr_hwdata), .M_HREADY(rr_m_hready),
    .M_HRDATA(rr_m_hrdata), .S_HADDR(rr_s_haddr), .S_HTRANS(rr_s_htrans),
    .S_HWRITE(rr_s_hwrite), .S_HSIZE(rr_s_hsize), .S_HWDATA(rr_s_hwdata),
    .S_HREADY(s_hready), .S_HRDATA(s_hrdata), .S_HMASTER(rr_s_hmaster)
  );

  exp_t fp_q[$];
  exp_t rr_q[$];
  int   fp_extra = 0;
  int   rr_extra = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fp_drive(input int m, input logic [1:0] t, input logic [31:0] a,
                          input logic w, input logic [31:0] d);
    fp_htrans[m*2 +: 2]  = t;
    fp_haddr[m*32 +: 32] = a;
    fp_hwrite[m]         = w;
    fp_hsize[m*3 +: 3]   = 3'b010;
    fp_hwdata[m*32 +: 32] = d;
  endtask

  task automatic rr_drive(input int m, input logic [1:0] t, input logic [31:0] a);
    rr_htrans[m*2 +: 2]  = t;
    rr_haddr[m*32 +: 32] = a;
  endtask

  task automatic fp_push(input logic [1:0] m, input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    e.m = m; e.addr = a; e.write = w; e.wdata = d;
    fp_q.push_back(e);
  endtask

  task automatic rr_push(input logic [1:0] m, input logic [31:0] a);
    exp_t e;
    e.m = m; e.addr = a; e.write = 1'b0; e.wdata = '0;
    rr_q.push_back(e);
  endtask

  // Fixed-priority monitor: pops on every accepted address phase and checks
  // write data / ready when that data phase completes.
  initial begin
    exp_t e;
    exp_t dp;
    logic dp_valid;
    dp_valid = 1'b0;
    dp = '0;
    forever begin
      @(negedge clk);
      if (srst) begin
        dp_valid = 1'b0;
      end else begin
        if (dp_valid && s_hready) begin
          if (dp.write) check_value("fp_dphase_wdata", 64'(fp_s_hwdata), 64'(dp.wdata));
          check_value("fp_dphase_ready", 64'(fp_m_hready[dp.m[0]]), 64'(1));
          dp_valid = 1'b0;
        end
        if (fp_s_htrans == NS && s_hready) begin
          if (fp_q.size() == 0) begin
            fp_extra++;
          end else begin
            e = fp_q.pop_front();
            check_value("fp_issue_addr", 64'(fp_s_haddr), 64'(e.addr));
            check_value("fp_issue_master", 64'(fp_s_hmaster), 64'(e.m));
            check_value("fp_issue_write", 64'(fp_s_hwrite), 64'(e.write));
            dp = e;
            dp_valid = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin monitor: issue order and addresses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!srst && rr_s_htrans == NS && s_hready) begin
        if (rr_q.size() == 0) begin
          rr_extra++;
        end else begin
          e = rr_q.pop_front();
          check_value("rr_issue_master", 64'(rr_s_hmaster), 64'(e.m));
          check_value("rr_issue_addr", 64'(rr_s_haddr), 64'(e.addr));
        end
      end
    end
  end

  initial begin
    int   cnt [3];
    logic [2:0] rdy;

    srst = 1'b1;
    s_hready = 1'b1;
    s_hrdata = 32'hCAFE_F00D;
    fp_haddr = '0; fp_hwdata = '0; fp_htrans = '0; fp_hwrite = '0; fp_hsize = '0;
    rr_haddr = '0; rr_hwdata = '0; rr_htrans = '0; rr_hwrite = '0; rr_hsize = '0;
    tick();
    tick();

    // Reset: outputs forced idle even with a request presented
    fp_drive(0, NS, 32'h0000_0900, 1'b1, 32'h0);
    @(negedge clk);
    check_value("rst_htrans", 64'(fp_s_htrans), 64'(ID));
    check_value("rst_haddr", 64'(fp_s_haddr), 64'(0));
    check_value("rst_hwrite", 64'(fp_s_hwrite), 64'(0));
    check_value("rst_hsize", 64'(fp_s_hsize), 64'(0));
    check_value("rst_hmaster", 64'(fp_s_hmaster), 64'(0));
    check_value("rst_fp_hready", 64'(fp_m_hready), 64'(2'b11));
    check_value("rst_rr_hready", 64'(rr_m_hready), 64'(3'b111));
    tick();
    fp_htrans = '0;
    srst = 1'b0;
    tick();

    // 1: master 0 alone, back-to-back reads
    fp_drive(0, NS, 32'h0000_0100, 1'b0, 32'h0);
    fp_push(2'd0, 32'h0000_0100, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t1_haddr_a", 64'(fp_s_haddr), 64'(32'h100));
    check_value("t1_hsize", 64'(fp_s_hsize), 64'(3'b010));
    check_value("t1_hready0_a", 64'(fp_m_hready[0]), 64'(1));
    tick();
    fp_drive(0, NS, 32'h0000_0104, 1'b0, 32'h0);
    fp_push(2'd0, 32'h0000_0104, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t1_haddr_b", 64'(fp_s_haddr), 64'(32'h104));
    check_value("t1_hready0_b", 64'(fp_m_hready[0]), 64'(1));
    check_value("t1_hmaster", 64'(fp_s_hmaster), 64'(0));
    tick();
    fp_htrans = '0;
    @(negedge clk);
    check_value("t1_idle_htrans", 64'(fp_s_htrans), 64'(ID));
    tick();

    // 2: simultaneous requests, fixed priority
    fp_drive(0, NS, 32'h0000_0100, 1'b0, 32'h0);
    fp_drive(1, NS, 32'h0000_0200, 1'b0, 32'h0);
    fp_push(2'd0, 32'h0000_0100, 1'b0, 32'h0);
    fp_push(2'd1, 32'h0000_0200, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t2_first_addr", 64'(fp_s_haddr), 64'(32'h100));
    check_value("t2_both_ready", 64'(fp_m_hready), 64'(2'b11));
    tick();
    fp_htrans = '0;
    @(negedge clk);
    check_value("t2_buf_addr", 64'(fp_s_haddr), 64'(32'h200));
    check_value("t2_buf_master", 64'(fp_s_hmaster), 64'(1));
    check_value("t2_hready1_low", 64'(fp_m_hready[1]), 64'(0));
    tick();
    @(negedge clk);
    check_value("t2_hready1_back", 64'(fp_m_hready[1]), 64'(1));
    tick();

    // 4: slave stall for 3 cycles with master 1 selected
    s_hready = 1'b0;
    fp_drive(1, NS, 32'h0000_0300, 1'b0, 32'h0);
    fp_push(2'd1, 32'h0000_0300, 1'b0, 32'h0);
    fp_push(2'd0, 32'h0000_0400, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t4_addr_c1", 64'(fp_s_haddr), 64'(32'h300));
    tick();
    fp_drive(1, ID, 32'h0, 1'b0, 32'h0);
    fp_drive(0, NS, 32'h0000_0400, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t4_addr_c2", 64'(fp_s_haddr), 64'(32'h300));
    check_value("t4_master_c2", 64'(fp_s_hmaster), 64'(1));
    tick();
    fp_drive(0, ID, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t4_addr_c3", 64'(fp_s_haddr), 64'(32'h300));
    check_value("t4_hready_c3", 64'(fp_m_hready), 64'(2'b00));
    tick();
    s_hready = 1'b1;
    @(negedge clk);
    check_value("t4_accept_master", 64'(fp_s_hmaster), 64'(1));
    tick();
    @(negedge clk);
    check_value("t4_follow_addr", 64'(fp_s_haddr), 64'(32'h400));
    tick();
    tick();

    // 5: buffered write from master 1
    fp_drive(0, NS, 32'h0000_0500, 1'b0, 32'h1111_1111);
    fp_drive(1, NS, 32'h0000_0600, 1'b1, 32'hDEAD_BEEF);
    fp_push(2'd0, 32'h0000_0500, 1'b0, 32'h1111_1111);
    fp_push(2'd1, 32'h0000_0600, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check_value("t5_first_addr", 64'(fp_s_haddr), 64'(32'h500));
    tick();
    fp_htrans = '0;
    @(negedge clk);
    check_value("t5_buf_write", 64'(fp_s_hwrite), 64'(1));
    check_value("t5_hready1_c2", 64'(fp_m_hready[1]), 64'(0));
    check_value("t5_hrdata", 64'(fp_m_hrdata), 64'(32'hCAFE_F00D));
    tick();
    s_hready = 1'b0;
    @(negedge clk);
    check_value("t5_hready1_stall", 64'(fp_m_hready[1]), 64'(0));
    check_value("t5_wdata_stall", 64'(fp_s_hwdata), 64'(32'hDEAD_BEEF));
    tick();
    s_hready = 1'b1;
    @(negedge clk);
    check_value("t5_hready1_done", 64'(fp_m_hready[1]), 64'(1));
    tick();
    tick();

    // 3: round-robin, three masters each issuing 3 reads continuously
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        rr_push(2'(i), 32'(32'h1000 * (i + 1) + 4 * r));
      end
    end
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < 3; i++) begin
        rr_drive(i, (cnt[i] < 3) ? NS : ID, 32'(32'h1000 * (i + 1) + 4 * cnt[i]));
      end
      @(negedge clk);
      rdy = rr_m_hready;
      tick();
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] && cnt[i] < 3) cnt[i]++;
      end
    end
    rr_htrans = '0;
    tick();

    // 6: reset while master 1 is pending
    fp_drive(0, NS, 32'h0000_0700, 1'b0, 32'h0);
    fp_drive(1, NS, 32'h0000_0800, 1'b0, 32'h0);
    fp_push(2'd0, 32'h0000_0700, 1'b0, 32'h0);
    @(negedge clk);
    check_value("t6_addr", 64'(fp_s_haddr), 64'(32'h700));
    tick();
    fp_htrans = '0;
    srst = 1'b1;
    @(negedge clk);
    check_value("t6_rst_htrans", 64'(fp_s_htrans), 64'(ID));
    check_value("t6_rst_hready", 64'(fp_m_hready), 64'(2'b11));
    tick();
    srst = 1'b0;
    @(negedge clk);
    check_value("t6_post_htrans", 64'(fp_s_htrans), 64'(ID));
    check_value("t6_post_hready", 64'(fp_m_hready), 64'(2'b11));
    repeat (4) tick();

    check_value("fp_queue_left", 64'(fp_q.size()), 64'(0));
    check_value("rr_queue_left", 64'(rr_q.size()), 64'(0));
    check_value("fp_extra_issues", 64'(fp_extra), 64'(0));
    check_value("rr_extra_issues", 64'(rr_extra), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
